// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, default latencies
// and FSM state type.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MFHI  = 3'd4;
  localparam logic [2:0] MD_MFLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;

  localparam int unsigned MD_MUL_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES = 10;

  typedef enum logic {StIdle, StRun} md_state_e;

  // Ops 0..3 are the multicycle multiply/divide family.
  function automatic logic is_muldiv(logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit multiply and 32-bit divide datapath for md_ctrl.
// Result is {res_hi, res_lo}; div_zero flags a divide whose divisor is zero.
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] a_s64, b_s64, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s, rem_s;
  logic        [31:0] quo_u, rem_u;
  logic               div_ovf;

  assign a_s64  = {{32{a[31]}}, a};
  assign b_s64  = {{32{b[31]}}, b};
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign div_zero = (b == 32'd0) && (op == MD_DIV || op == MD_DIVU);
  // Substitute 1 so the divider never sees zero; the result is discarded anyway.
  assign b_safe   = (b == 32'd0) ? 32'd1 : b;
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    quo_s = $signed(a) / $signed(b_safe);
    rem_s = $signed(a) % $signed(b_safe);
    // Most-negative / -1 overflows 32-bit signed division; wrap the quotient explicitly.
    if (div_ovf) begin
      quo_s = 32'sh8000_0000;
      rem_s = 32'sd0;
    end
  end

  assign quo_u = a / b_safe;
  assign rem_u = a % b_safe;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_hi = rem_s;
        res_lo = quo_s;
      end
      MD_DIVU: begin
        res_hi = rem_u;
        res_lo = quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer beside the Execute-stage ALU: owns HI/LO, runs MULT/DIV as
// fixed-latency multicycle ops, serves MF/MT moves and honours exception flush.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] MulCnt = 4'(MUL_CYCLES);
  localparam logic [3:0] DivCnt = 4'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_zero_q, pend_zero_d;

  logic [31:0] calc_hi, calc_lo;
  logic        calc_zero;
  logic        accept;

  md_calc u_calc (
    .op       (op),
    .a        (rs_data),
    .b        (rt_data),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .div_zero (calc_zero)
  );

  assign accept = start && !flush && (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_zero_d = pend_zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_muldiv(op)) begin
            pend_hi_d   = calc_hi;
            pend_lo_d   = calc_lo;
            pend_zero_d = calc_zero;
            cnt_d       = op[1] ? DivCnt : MulCnt;
            state_d     = StRun;
          end else if (op == MD_MTHI) begin
            hi_d = rs_data;
          end else if (op == MD_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      StRun: begin
        if (flush) begin
          // Cancelled instruction: drop the pending result, HI/LO untouched.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = StIdle;
            if (!pend_zero_q) begin
              hi_d = pend_hi_q;
              lo_d = pend_lo_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_zero_q <= pend_zero_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign md_out = (op == MD_MFHI) ? hi_q :
                  (op == MD_MFLO) ? lo_q : 32'd0;

  // The hazard unit must hold off new ops while a multicycle op is running.
  a_no_start_when_busy : assert property (@(posedge clk) disable iff (!reset_n)
    !(start && busy));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl with hand-computed HI/LO expectations.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  md_ctrl #(
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, then return #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic f);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    flush   = f;
    step();
    start = 1'b0;
    flush = 1'b0;
    op    = 3'd0;
  endtask

  // Count busy-high cycles until busy falls, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(o, a, b, 1'b0);
    count_busy(n);
    check({tag, " busy cycles"}, 64'(n), 64'(cycles));
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    int seen_busy;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    flush   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);

    run_op("mult",   3'd0, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",  3'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div",    3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",   3'd3, 32'd7,         32'd2, 10, 32'd1,         32'd3);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("div0",   3'd2, 32'd5,         32'd0, 10, 32'd0,         32'h8000_0000);

    // Flush on the third busy cycle of a MULT.
    issue(3'd0, 32'd2, 32'd3, 1'b0);
    step();
    step();
    check("flush busy before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy after", {63'd0, busy}, 64'd0);
    repeat (6) step();
    check("flush hi", {32'd0, hi}, 64'd0);
    check("flush lo", {32'd0, lo}, 64'h8000_0000);

    // start together with flush never begins an op.
    issue(3'd0, 32'd2, 32'd3, 1'b1);
    seen_busy = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) seen_busy++;
      step();
    end
    check("start+flush busy", 64'(seen_busy), 64'd0);
    check("start+flush lo", {32'd0, lo}, 64'h8000_0000);

    issue(3'd6, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi busy", {63'd0, busy}, 64'd0);
    check("mthi hi", {32'd0, hi}, 64'h1234_5678);

    op = 3'd4;
    #1;
    check("mfhi md_out", {32'd0, md_out}, 64'h1234_5678);
    op = 3'd5;
    #1;
    check("mflo md_out", {32'd0, md_out}, 64'h8000_0000);
    op = 3'd0;
    #1;
    check("md_out idle", {32'd0, md_out}, 64'd0);

    issue(3'd7, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("mtlo flush lo", {32'd0, lo}, 64'h8000_0000);
    issue(3'd7, 32'hCAFE_F00D, 32'd0, 1'b0);
    check("mtlo lo", {32'd0, lo}, 64'hCAFE_F00D);

    // Asynchronous reset in the middle of a DIV.
    issue(3'd2, 32'd100, 32'd7, 1'b0);
    step();
    check("pre-reset busy", {63'd0, busy}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy", {63'd0, busy}, 64'd0);
    check("async reset hi", {32'd0, hi}, 64'd0);
    check("async reset lo", {32'd0, lo}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer for the Execute stage of the P7 pipelined MIPS core, sitting beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU from E and runs them as fixed-latency multicycle operations.
- Owns the HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and drives a busy flag for hazard/stall control.
- Honours exception flush so a cancelled instruction never changes HI/LO.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  qualifies op in E this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
- rs_data  input  32  operand A (dividend/multiplicand/MT source)
- rt_data  input  32  operand B (divisor/multiplier)
- flush  input  1  exception/interrupt cancel for the instruction in E
- busy  output  1  operation in progress
- hi  output  32  architectural HI
- lo  output  32  architectural LO
- md_out  output  32  combinational: hi when op==MFHI, lo when op==MFLO, else 0

Behaviour:
- Reset (async, reset_n low): hi=0, lo=0, busy=0, state=IDLE, cnt=0, pending regs=0. Reset mid-operation abandons the op immediately.
- States:
  - IDLE: accept ops.
  - RUN: counting down.
- Accept condition: start && !flush && state==IDLE.
- Mul/div accepted at edge T:
  - Compute 64-bit result combinationally from rs_data/rt_data and latch it into pend_hi/pend_lo.
  - Load cnt with MUL_CYCLES or DIV_CYCLES; go to RUN.
  - busy=1 for cycles T+1 .. T+N (exactly N cycles).
- RUN:
  - Each edge decrements cnt.
  - At the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, busy->0, state->IDLE.
  - New values are visible in the first cycle busy is 0.
- Multiply:
  - MULT is signed 32x32->64; MULTU is unsigned.
  - {hi,lo} = product.
- Divide:
  - lo=quotient, hi=remainder; truncation toward zero; remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divisor 0: the op still takes DIV_CYCLES but hi/lo stay unchanged.
- MTHI/MTLO accepted: hi (resp. lo) <= rs_data at that edge, with no busy. Flush in the same cycle suppresses the write.
- MFHI/MFLO: purely combinational read via md_out; never stalls in md_ctrl. The hazard unit stalls the reader while start&&op<4 or busy.
- start while RUN: ignored, with no state change. The hazard unit guarantees this never occurs. Assertion: start && busy must never hold.
- flush while RUN: abort at that edge. state->IDLE, busy->0, hi/lo unchanged, pending discarded.
- flush with a start in the same cycle: start ignored.
- Counter width: 4 bits; no wrap, since cnt stops at 0 in IDLE.

Decomposition:
- Shared package (md_pkg / header): op encodings MD_MULT..MD_MTLO and default latencies.
- One sub-module, md_calc: purely combinational 64-bit signed/unsigned multiply and divide, plus the divide-by-zero flag.
- md_ctrl holds the FSM, counter, and HI/LO registers.

Test Plan:
- Reset: reset_n low mid-RUN -> busy=0, hi=lo=0 immediately, without waiting for clk.
- MULT: rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV: rs=-7, rt=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU: 7/2 -> lo=3, hi=1.
- DIV corner cases:
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIV by 0 -> 10 busy cycles, hi/lo unchanged.
- Flush:
  - MULT start, flush on 3rd busy cycle -> busy drops next cycle, hi/lo keep prior values.
  - start+flush together -> busy never rises.
- MTHI/MFHI:
  - MTHI rs=0x12345678 -> hi updates next cycle, no busy.
  - MFHI -> md_out=0x12345678 combinationally.
  - MTLO with flush -> lo unchanged.
